// File: rtl/uart_frame_sched.sv
// uart_frame_sched: round-robin frame scheduler that lets N_REQ byte-stream
// requesters share one UART transmitter without interleaving frames.
//
// Once a requester is granted, it owns the UART until its last byte has gone
// out. Each byte goes through FETCH -> TX -> GUARD -> DRAIN. GUARD gives the
// UART two cycles to raise BUSY, so DRAIN never mistakes a UART that has not
// started yet for one that has finished.
//
// Optional feature: define UART_SCHED_TIMEOUT_EN to abort a frame whose owner
// stalls in FETCH for TIMEOUT_CYC cycles. Without the macro, FETCH waits
// indefinitely, abort is tied low and no counter exists.
//
// Handshake: a requester byte moves when req_valid[i] and req_ready[i] are
// both high on a rising clk edge. req_ready is high only for the granted
// requester and only in FETCH. Requesters must hold valid/data/last stable
// until that edge.

`default_nettype none

module uart_frame_sched #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               BUSY,
  output logic [7:0]         DATA_out,
  output logic               SEND,
  output logic [N_REQ-1:0]   grant,
  output logic               frame_done,
  output logic               abort
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    TX    = 3'd2,
    GUARD = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;        // last served requester; the scan starts after it
  logic [IW-1:0] g_idx;      // index of the current owner
  logic          last_r;     // captured byte closes the frame
  logic          guard_cnt;  // GUARD cycle count (0 then 1)

  // round-robin pick results
  logic          found;
  logic [IW-1:0] pick;

  // owner's request lines, muxed by g_idx
  logic          cur_valid;
  logic [7:0]    cur_data;
  logic          cur_last;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;     // stall cycles spent in FETCH for this byte
`endif

  // Round-robin scan: first requester with valid high, starting at ptr+1.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(ptr) + k) % N_REQ;
      cand_idx = cand[IW-1:0];
      if (!found && req_valid[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // Select the owner's valid, data and last bits.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = 8'h00;
    cur_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_idx == i[IW-1:0]) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[8*i +: 8];
        cur_last  = req_last[i];
      end
    end
  end

  // Ready goes only to the owner, and only while a byte is being fetched.
  assign req_ready = (state == FETCH) ? grant : '0;

  // Frame scheduler FSM with registered UART strobe, grant and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IW'(N_REQ - 1);
      g_idx      <= '0;
      grant      <= '0;
      DATA_out   <= 8'h00;
      SEND       <= 1'b0;
      frame_done <= 1'b0;
      last_r     <= 1'b0;
      guard_cnt  <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      abort      <= 1'b0;
      to_cnt     <= '0;
`endif
    end else begin
      // strobes are one cycle wide unless re-asserted below
      SEND       <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      abort      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            g_idx <= pick;
            grant <= N_REQ'(1) << pick;
            state <= FETCH;
`ifdef UART_SCHED_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end

        FETCH: begin
          if (cur_valid) begin
            // DATA_out only ever changes here, so it is stable for the UART
            DATA_out <= cur_data;
            last_r   <= cur_last;
            state    <= TX;
          end
`ifdef UART_SCHED_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            abort <= 1'b1;
            grant <= '0;
            ptr   <= g_idx;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        TX: begin
          if (!BUSY) begin
            SEND      <= 1'b1;
            guard_cnt <= 1'b0;
            state     <= GUARD;
          end
        end

        GUARD: begin
          // two cycles regardless of BUSY, giving the UART time to react
          if (guard_cnt) begin
            state <= DRAIN;
          end else begin
            guard_cnt <= 1'b1;
          end
        end

        DRAIN: begin
          if (!BUSY) begin
            if (last_r) begin
              frame_done <= 1'b1;
              ptr        <= g_idx;
              grant      <= '0;
              state      <= IDLE;
            end else begin
              state <= FETCH;
`ifdef UART_SCHED_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end
          end
        end

        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifndef UART_SCHED_TIMEOUT_EN
  assign abort = 1'b0;
`endif

  // Protocol properties: one owner at most, one-cycle SEND, DATA_out only
  // changes on an edge taken in FETCH.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_send_single: assert property (@(posedge clk) disable iff (!rst_n)
    SEND |=> !SEND);
  a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state != FETCH) |=> $stable(DATA_out));

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_sched.sv
// Bench for uart_frame_sched (N_REQ=4, TIMEOUT_CYC=16). Stimulus pushes
// expected UART events into exp_q; a monitor pops and compares on every
// SEND / frame_done / abort. Expected orders and cycle gaps are hand-derived.
module tb_uart_frame_sched;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           BUSY;
  logic [7:0]     DATA_out;
  logic           SEND;
  logic [N-1:0]   grant;
  logic           frame_done;
  logic           abort;

  uart_frame_sched #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .BUSY(BUSY), .DATA_out(DATA_out), .SEND(SEND),
    .grant(grant), .frame_done(frame_done), .abort(abort)
  );

  // ---------------- UART model ----------------
  // BUSY rises two edges after SEND is seen and stays high busy_hold cycles.
  logic send_d;
  int   busy_cnt;
  int   busy_hold = 10;
  logic force_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_d   <= 1'b0;
      busy_cnt <= 0;
    end else begin
      send_d <= SEND;
      if (send_d) busy_cnt <= busy_hold;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end
  assign BUSY = (busy_cnt != 0) || force_busy;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  int send_cyc_q[$];
  int send_count = 0;
  int done_cyc   = 0;
  int abort_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic exp_send(input logic [3:0] g, input logic [7:0] d);
    exp_q.push_back({4'h1, g, d});
  endtask
  task automatic exp_done();
    exp_q.push_back(16'h2000);
  endtask
  task automatic exp_abort();
    exp_q.push_back(16'h4000);
  endtask

  // ---------------- requester driver ----------------
  logic [8:0] q0[$], q1[$], q2[$], q3[$];   // {last, data}

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    case (r)
      0: q0.push_back({l, d});
      1: q1.push_back({l, d});
      2: q2.push_back({l, d});
      default: q3.push_back({l, d});
    endcase
  endtask

  function automatic int qsize(input int r);
    case (r)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [8:0] qhead(input int r);
    case (r)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int r);
    case (r)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  logic [N-1:0] fire_pend;
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fire_pend = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) fire_pend = '0;
      for (int i = 0; i < N; i++) begin
        if (fire_pend[i] && qsize(i) > 0) qpop(i);
      end
      for (int i = 0; i < N; i++) begin
        logic [8:0] h;
        if (qsize(i) > 0) begin
          h = qhead(i);
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = h[7:0];
          req_last[i]         = h[8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
      fire_pend = rst_n ? (req_valid & req_ready) : '0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check_event(input string name, input logic [15:0] act);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_unexpected: got=%0h expected=none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got=%0h expected=%0h", name, act, e);
      end
    end
  endtask

  initial begin
    logic       prev_send;
    logic [7:0] prev_data;
    logic       prev_fire;
    logic       prev_rstn;
    prev_send = 1'b0;
    prev_data = 8'h00;
    prev_fire = 1'b0;
    prev_rstn = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (SEND) begin
        check("send_width", {31'd0, prev_send}, 32'd0);
        check_event("send_event", {4'h1, grant, DATA_out});
        send_count++;
        send_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
        check_event("done_event", 16'h2000);
        check("grant_after_done", {28'd0, grant}, 32'd0);
        done_cyc = cyc;
      end
      if (abort) begin
        check_event("abort_event", 16'h4000);
        check("grant_after_abort", {28'd0, grant}, 32'd0);
        abort_cyc = cyc;
      end
      if (rst_n && prev_rstn && (DATA_out !== prev_data))
        check("data_stable", {31'd0, prev_fire}, 32'd1);
      prev_send = SEND;
      prev_data = DATA_out;
      prev_fire = |(req_valid & req_ready);
      prev_rstn = rst_n;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_exp_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  {24'd0, DATA_out}, 32'd0);
    check({tag, "_send"},  {31'd0, SEND}, 32'd0);
    check({tag, "_grant"}, {28'd0, grant}, 32'd0);
    check({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
    check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
    check({tag, "_abort"}, {31'd0, abort}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int base;
    int n;
    int stall_sends;
    rst_n      = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3-byte frame from requester 0, UART busy 10 cycles per byte
    send_cyc_q.delete();
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b0);
    push_byte(0, 8'h33, 1'b1);
    exp_send(4'b0001, 8'h11);
    exp_send(4'b0001, 8'h22);
    exp_send(4'b0001, 8'h33);
    exp_done();
    wait_exp_empty("frame3_drain", 300);
    if (send_cyc_q.size() == 3) begin
      // BUSY up 2 edges after SEND, 10 cycles high, then DRAIN/FETCH/TX: 15
      check("gap_b0_b1", send_cyc_q[1] - send_cyc_q[0], 15);
      check("gap_b1_b2", send_cyc_q[2] - send_cyc_q[1], 15);
      check("done_latency", done_cyc - send_cyc_q[2], 13);
    end else begin
      check("frame3_send_count", send_cyc_q.size(), 3);
    end
    check("idle_grant", {28'd0, grant}, 32'd0);

    // requesters 1 and 2 together after reset: 1 first, no interleaving
    pulse_reset();
    push_byte(1, 8'hA1, 1'b0);
    push_byte(1, 8'hA2, 1'b1);
    push_byte(2, 8'hB1, 1'b0);
    push_byte(2, 8'hB2, 1'b1);
    exp_send(4'b0010, 8'hA1);
    exp_send(4'b0010, 8'hA2);
    exp_done();
    exp_send(4'b0100, 8'hB1);
    exp_send(4'b0100, 8'hB2);
    exp_done();
    wait_exp_empty("pair_drain", 400);

    // fairness: r0 holds valid for two frames, r1 gets served in between
    push_byte(0, 8'hC1, 1'b1);
    push_byte(0, 8'hC2, 1'b1);
    push_byte(1, 8'hD1, 1'b1);
    exp_send(4'b0001, 8'hC1);
    exp_done();
    exp_send(4'b0010, 8'hD1);
    exp_done();
    exp_send(4'b0001, 8'hC2);
    exp_done();
    wait_exp_empty("fair_drain", 400);

    // BUSY held 50 cycles with a byte captured
    force_busy = 1'b1;
    push_byte(3, 8'hE1, 1'b1);
    exp_send(4'b1000, 8'hE1);
    exp_done();
    stall_sends = 0;
    repeat (50) begin
      @(negedge clk);
      if (SEND) stall_sends++;
    end
    check("stall_no_send", stall_sends, 0);
    check("stall_data_captured", {24'd0, DATA_out}, 32'hE1);
    force_busy = 1'b0;
    @(negedge clk);
    check("send_after_busy", {31'd0, SEND}, 32'd1);
    @(negedge clk);
    check("send_one_cycle", {31'd0, SEND}, 32'd0);
    wait_exp_empty("stall_drain", 200);

    // reset between 2nd and 3rd SEND of a 5-byte frame
    base = send_count;
    push_byte(2, 8'h51, 1'b0);
    push_byte(2, 8'h52, 1'b0);
    push_byte(2, 8'h53, 1'b0);
    push_byte(2, 8'h54, 1'b0);
    push_byte(2, 8'h55, 1'b1);
    exp_send(4'b0100, 8'h51);
    exp_send(4'b0100, 8'h52);
    n = 0;
    while (send_count < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_frame_two_sends", send_count - base, 2);
    repeat (3) @(negedge clk);
    q2.delete();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_send_after_reset", send_count - base, 2);
    push_byte(3, 8'hF3, 1'b1);
    push_byte(0, 8'hF0, 1'b1);
    exp_send(4'b0001, 8'hF0);
    exp_done();
    exp_send(4'b1000, 8'hF3);
    exp_done();
    wait_exp_empty("post_reset_drain", 300);

    // owner drops valid mid-frame while requester 2 is pending
    send_cyc_q.delete();
    push_byte(1, 8'h61, 1'b0);
    push_byte(1, 8'h62, 1'b0);
    push_byte(2, 8'h71, 1'b1);
    exp_send(4'b0010, 8'h61);
    exp_send(4'b0010, 8'h62);
`ifdef UART_SCHED_TIMEOUT_EN
    exp_abort();
    exp_send(4'b0100, 8'h71);
    exp_done();
    wait_exp_empty("timeout_drain", 400);
    if (send_cyc_q.size() >= 2)
      check("abort_latency", abort_cyc - send_cyc_q[1], 29);
    else
      check("timeout_send_count", send_cyc_q.size(), 2);
    check("timeout_grant_idle", {28'd0, grant}, 32'd0);
`else
    wait_exp_empty("stall_frame_drain", 300);
    repeat (100) @(negedge clk);
    check("stall_grant_held", {28'd0, grant}, 32'b0010);
    check("stall_ready_held", {28'd0, req_ready}, 32'b0010);
    check("stall_no_abort", {31'd0, abort}, 32'd0);
`endif

    check("exp_q_empty_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
